// File: rtl/fmt_receiver.sv
// Packet receiver: grants the formatter once FIFO space is available, captures
// framed beats into a word FIFO tagged with channel ID, and keeps sticky error flags.
module fmt_receiver #(
  parameter int DEPTH         = 64,
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fmt_req,
  input  logic [1:0]  fmt_chid,
  input  logic [5:0]  fmt_length,
  input  logic        fmt_start,
  input  logic        fmt_end,
  input  logic [31:0] fmt_data,
  output logic        fmt_grant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [1:0]  out_chid,
  output logic [15:0] pkt_cnt,
  output logic [2:0]  err,
  input  logic        err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, DATA} state_t;
  state_t state, state_nxt;

  logic [1:0]    chid_q;
  logic [5:0]    len_q, beat_q, beat_num;
  logic [TW-1:0] tmo_q;
  logic [AW:0]   count, free;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [34:0]   mem [DEPTH];
  logic          push, pop, close, latch, set_len, set_frame, set_tmo;

  assign free     = (AW+1)'(DEPTH) - count;
  assign beat_num = (state == WAIT_START) ? 6'd1 : beat_q + 6'd1;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // Gate the read port so outputs read as zero while empty (including after reset).
  assign {out_chid, out_last, out_data} = out_valid ? mem[rd_ptr] : 35'd0;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    fmt_grant = 1'b0;
    push      = 1'b0;
    close     = 1'b0;
    latch     = 1'b0;
    set_len   = 1'b0;
    set_frame = 1'b0;
    set_tmo   = 1'b0;
    case (state)
      IDLE: if (fmt_req) begin
        if (fmt_length == 6'd0) set_len = 1'b1;
        else if (free >= (AW+1)'(fmt_length)) begin
          latch     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        fmt_grant = 1'b1;
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (fmt_start) push = 1'b1;
        else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end
        if (fmt_start) state_nxt = DATA;
      end
      DATA: push = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // Packet closes on fmt_end or on reaching length; framing is bad if those disagree.
    if (push) begin
      close     = fmt_end || (beat_num == len_q);
      set_frame = (fmt_end != (beat_num == len_q)) || (state == DATA && fmt_start);
      if (close) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {chid_q, close, fmt_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chid_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
      err     <= '0;
    end else begin
      if (latch) begin
        chid_q <= fmt_chid;
        len_q  <= fmt_length;
      end
      if (push) beat_q <= close ? 6'd0 : beat_num;
      tmo_q <= (state == WAIT_START && state_nxt == WAIT_START) ? tmo_q + TW'(1) : '0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (close) pkt_cnt <= pkt_cnt + 16'd1;
      err <= (err_clr ? 3'b000 : err) | {set_tmo, set_frame, set_len};
    end
  end
endmodule

// File: tb/tb_fmt_receiver.sv
// Directed bench for fmt_receiver: a queue of expected FIFO words built from the
// packets sent, plus expected pkt_cnt/err derived from the framing rules.
module tb_fmt_receiver;
  logic        clk = 0, rstn = 0;
  logic        fmt_req = 0, fmt_start = 0, fmt_end = 0, err_clr = 0, out_ready = 1;
  logic [1:0]  fmt_chid = 0;
  logic [5:0]  fmt_length = 0;
  logic [31:0] fmt_data = 0;
  logic        fmt_grant, out_valid, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_chid;
  logic [15:0] pkt_cnt;
  logic [2:0]  err;

  int checks = 0, fails = 0;
  logic [34:0] q[$];
  logic [15:0] exp_pkt = 0;
  logic [2:0]  exp_err = 0;

  fmt_receiver #(.DEPTH(64), .START_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .fmt_req(fmt_req), .fmt_chid(fmt_chid),
    .fmt_length(fmt_length), .fmt_start(fmt_start), .fmt_end(fmt_end),
    .fmt_data(fmt_data), .fmt_grant(fmt_grant), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_chid(out_chid), .pkt_cnt(pkt_cnt), .err(err), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every word the DUT presents must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL word: got unexpected %0h, none expected", {out_chid, out_last, out_data});
      end else begin
        if ({out_chid, out_last, out_data} !== q[0]) begin
          fails++;
          $display("FAIL word: got %0h expected %0h", {out_chid, out_last, out_data}, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic req_grant(input logic [1:0] ch, input int len, output bit got);
    fmt_req = 1; fmt_chid = ch; fmt_length = len[5:0]; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (fmt_grant) begin got = 1; break; end
    end
    fmt_req = 0; fmt_chid = 0; fmt_length = 0;
    check("grant seen", 64'(got), 64'd1);
  endtask

  // end_at=0: no fmt_end; extra_start: beat with a spurious fmt_start; rst_at: reset pulse at that beat.
  task automatic send_pkt(input logic [1:0] ch, input int len, input int end_at,
                          input int extra_start, input int rst_at, input logic [31:0] base);
    bit got;
    int n_close;
    bit frame;
    n_close = (end_at >= 1 && end_at <= len) ? end_at : len;
    frame   = (end_at != len) || (extra_start >= 2 && extra_start <= n_close);
    req_grant(ch, len, got);
    if (!got) return;
    @(posedge clk); #1;
    check("grant width", 64'(fmt_grant), 64'd0);
    for (int n = 1; n <= n_close; n++) begin
      if (n == rst_at) begin
        rstn = 0; #1;
        check("async reset outs", {fmt_grant, out_valid, out_last, out_chid, out_data, pkt_cnt, err}, 64'd0);
        rstn = 1;
        q.delete(); exp_pkt = 0; exp_err = 0;
        fmt_start = 0; fmt_end = 0; fmt_data = 0;
        return;
      end
      fmt_start = (n == 1) || (n == extra_start);
      fmt_end   = (n == end_at);
      fmt_data  = base + 32'(n);
      q.push_back({ch, (n == n_close), base + 32'(n)});
      @(posedge clk); #1;
    end
    fmt_start = 0; fmt_end = 0; fmt_data = 0;
    exp_pkt++;
    if (frame) exp_err |= 3'b010;
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    check("err", 64'(err), 64'(exp_err));
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0) break;
    end
    check("drain queue", 64'(q.size()), 64'd0);
    check("drain empty", 64'(out_valid), 64'd0);
  endtask

  task automatic clear_err();
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    exp_err = 0;
    check("err cleared", 64'(err), 64'd0);
  endtask

  initial begin
    bit got;
    repeat (2) @(posedge clk); #1;
    check("reset outs", {fmt_grant, out_valid, out_last, out_chid, out_data, pkt_cnt, err}, 64'd0);
    rstn = 1;
    @(posedge clk); #1;

    // basic 4-word packet on chid 2
    send_pkt(2'd2, 4, 4, 0, 0, 32'hA000_0000);
    check("basic pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("basic err", 64'(err), 64'd0);
    drain();

    // single-beat packet: start and end on the same beat
    send_pkt(2'd1, 1, 1, 0, 0, 32'hB000_0000);
    check("len1 err", 64'(err), 64'd0);
    drain();

    // zero length: error, no grant, then clear; clear plus new error keeps the new one
    fmt_req = 1; fmt_length = 0; fmt_chid = 3;
    @(posedge clk); #1;
    check("len0 err", 64'(err), 64'd1);
    check("len0 no grant", 64'(fmt_grant), 64'd0);
    fmt_req = 0;
    @(posedge clk); #1;
    check("len0 still no grant", 64'(fmt_grant), 64'd0);
    clear_err();
    fmt_req = 1; err_clr = 1;
    @(posedge clk); #1;
    fmt_req = 0; err_clr = 0;
    check("clr vs new err", 64'(err), 64'd1);
    clear_err();

    // spurious start on beat 2
    send_pkt(2'd3, 3, 3, 2, 0, 32'hC000_0000);
    check("restart err", 64'(err), 64'b010);
    drain();
    clear_err();

    // missing end on last beat still closes the packet
    send_pkt(2'd0, 2, 0, 0, 0, 32'hD000_0000);
    check("no end err", 64'(err), 64'b010);
    drain();
    clear_err();

    // early end at beat 5 of 8, then a fresh request is granted
    send_pkt(2'd1, 8, 5, 0, 0, 32'hE000_0000);
    check("early end err1", 64'(err[1]), 64'd1);
    drain();
    send_pkt(2'd2, 3, 3, 0, 0, 32'hE100_0000);
    drain();
    clear_err();

    // start timeout: 16 idle WAIT_START cycles
    req_grant(2'd1, 4, got);
    repeat (16) @(posedge clk);
    #1;
    check("tmo not yet", 64'(err), 64'd0);
    @(posedge clk); #1;
    check("tmo err", 64'(err), 64'b100);
    check("tmo fifo empty", 64'(out_valid), 64'd0);
    exp_err = 3'b100;
    send_pkt(2'd0, 2, 2, 0, 0, 32'hF000_0000);
    drain();
    clear_err();

    // backpressure: 62 words held, a 4-word request must wait for two pops
    out_ready = 0;
    send_pkt(2'd0, 62, 62, 0, 0, 32'h1000_0000);
    fmt_req = 1; fmt_length = 4; fmt_chid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      check("full no grant", 64'(fmt_grant), 64'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("pop1 no grant", 64'(fmt_grant), 64'd0);
    @(posedge clk); #1;
    check("pop2 no grant", 64'(fmt_grant), 64'd0);
    out_ready = 0;
    send_pkt(2'd1, 4, 4, 0, 0, 32'h2000_0000);
    check("full words held", 64'(q.size()), 64'd64);
    drain();

    // reset during beat 3 of 8, then a clean 2-word packet
    send_pkt(2'd2, 8, 8, 0, 3, 32'h3000_0000);
    check("post reset empty", 64'(out_valid), 64'd0);
    send_pkt(2'd3, 2, 2, 0, 0, 32'h4000_0000);
    check("post reset pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("post reset err", 64'(err), 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
